// File: rtl/bus_arb16.sv
// 16-requester arbiter with a registered one-entry output stage, round-robin or fixed priority.
// Latency: one edge from the request cycle to out_valid; gnt is combinational in the arbitration cycle.
// Backpressure: a held transfer stays frozen while out_ready is low; req is ignored until it is accepted.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   req[15:0]           per-requester level request
//   in_data[255:0]      requester i drives bits [16i+15:16i]
//   gnt[15:0]           one-hot capture pulse to the winner, only in arbitration cycles
//   out_data, out_sel   registered word and source index of the pending transfer
//   out_valid, busy     a transfer is pending (busy mirrors out_valid)
//   out_ready           downstream accepts when out_valid && out_ready
module bus_arb16 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  req,
  input  logic [255:0] in_data,
  output logic [15:0]  gnt,
  output logic [15:0]  out_data,
  output logic [3:0]   out_sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  ptr_q, ptr_d;

  logic [3:0]  base;
  logic [15:0] req_rot;
  logic [3:0]  off;
  logic [3:0]  win_idx;
  logic [15:0] win_data;
  logic        arb_en;

  // Fixed priority is round-robin with the scan origin pinned at requester 0.
  assign base = RR_EN ? ptr_q : 4'h0;

  // Rotate so the scan origin lands at bit 0; the lowest set bit of the
  // rotated vector is then the winner's distance from the origin.
  always_comb begin
    req_rot = 16'({req, req} >> base);
  end

  always_comb begin
    off = 4'h0;
    for (int i = 15; i >= 0; i--) begin
      if (req_rot[i]) off = 4'(i);
    end
  end

  assign win_idx  = base + off;               // wraps modulo 16
  assign win_data = in_data[{win_idx, 4'h0} +: 16];

  // An occupied output stage can be refilled in the same cycle it drains,
  // which is what makes back-to-back transfers bubble-free. rst_n gates the
  // grant so no requester sees a capture pulse that reset will discard.
  assign arb_en = rst_n && (req != 16'h0000) && ((state_q == IDLE) || out_ready);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    gnt     = 16'h0000;
    if (arb_en) begin
      gnt     = 16'h0001 << win_idx;
      state_d = HOLD;
      data_d  = win_data;
      sel_d   = win_idx;
      if (RR_EN) ptr_d = win_idx + 4'h1;
    end else if ((state_q == HOLD) && out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= 16'h0000;
      sel_q   <= 4'h0;
      ptr_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = (state_q == HOLD);
  assign busy      = out_valid;

endmodule

// File: tb/tb_bus_arb16.sv
module tb_bus_arb16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  req;
  logic [255:0] in_data;
  logic         out_ready;

  logic [15:0] gnt_rr, gnt_fp, od_rr, od_fp;
  logic [3:0]  os_rr, os_fp;
  logic        ov_rr, ov_fp, busy_rr, busy_fp;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  bus_arb16 #(.RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data), .gnt(gnt_rr),
    .out_data(od_rr), .out_sel(os_rr), .out_valid(ov_rr), .out_ready(out_ready), .busy(busy_rr)
  );

  bus_arb16 #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data), .gnt(gnt_fp),
    .out_data(od_fp), .out_sel(os_fp), .out_valid(ov_fp), .out_ready(out_ready), .busy(busy_fp)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state per instance: [0] round-robin, [1] fixed priority.
  bit          mv[2] = '{1'b0, 1'b0};
  logic [15:0] md[2] = '{16'h0, 16'h0};
  logic [3:0]  ms[2] = '{4'h0, 4'h0};
  logic [3:0]  mp[2] = '{4'h0, 4'h0};

  // Winner: first set request scanning upward from the origin, modulo 16.
  function automatic int pick(input int m, input logic [15:0] r, input logic [3:0] p);
    int start;
    start = (m == 0) ? int'(p) : 0;
    for (int k = 0; k < 16; k++) begin
      if (r[(start + k) % 16]) return (start + k) % 16;
    end
    return -1;
  endfunction

  // Inputs change just after posedge, so at negedge they are the values the
  // next edge will sample; the model advances here using exactly those.
  always @(negedge clk) begin
    int          w;
    bit          arb;
    logic [15:0] exp_g, g_act, d_act;
    logic [3:0]  s_act;
    logic        v_act, b_act;
    for (int m = 0; m < 2; m++) begin
      g_act = (m == 0) ? gnt_rr  : gnt_fp;
      d_act = (m == 0) ? od_rr   : od_fp;
      s_act = (m == 0) ? os_rr   : os_fp;
      v_act = (m == 0) ? ov_rr   : ov_fp;
      b_act = (m == 0) ? busy_rr : busy_fp;
      w     = -1;
      exp_g = 16'h0000;
      arb   = (rst_n === 1'b1) && (req != 16'h0000) && (!mv[m] || (out_ready === 1'b1));
      if (arb) begin
        w     = pick(m, req, mp[m]);
        exp_g = 16'h0001 << w;
      end
      if (cmp_en) begin
        chk($sformatf("model%0d gnt", m), 32'(g_act), 32'(exp_g));
        chk($sformatf("model%0d out_valid", m), 32'(v_act), 32'(mv[m]));
        chk($sformatf("model%0d busy", m), 32'(b_act), 32'(mv[m]));
        if (mv[m]) begin
          chk($sformatf("model%0d out_data", m), 32'(d_act), 32'(md[m]));
          chk($sformatf("model%0d out_sel", m), 32'(s_act), 32'(ms[m]));
        end
      end
      if (rst_n !== 1'b1) begin
        mv[m] = 1'b0; md[m] = 16'h0; ms[m] = 4'h0; mp[m] = 4'h0;
      end else if (arb) begin
        mv[m] = 1'b1;
        md[m] = in_data[w*16 +: 16];
        ms[m] = 4'(w);
        if (m == 0) mp[m] = 4'((w + 1) % 16);
      end else if (mv[m] && out_ready) begin
        mv[m] = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 16'h0000;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    tick();
    cmp_en = 1'b1;
    tick();
    rst_n = 1'b1;
    at_neg();
    chk("reset out_valid", 32'(ov_rr), 32'h0);
    chk("reset out_data", 32'(od_rr), 32'h0);
    chk("reset out_sel", 32'(os_rr), 32'h0);
    chk("reset gnt idle", 32'(gnt_rr), 32'h0);

    // Single request from requester 4, then drain
    tick();
    req = 16'h0010;
    in_data[79:64] = 16'hBEEF;
    out_ready = 1'b1;
    at_neg();
    chk("single gnt rr", 32'(gnt_rr), 32'h0010);
    chk("single gnt fp", 32'(gnt_fp), 32'h0010);
    tick();
    req = 16'h0000;
    at_neg();
    chk("single out_valid", 32'(ov_rr), 32'h1);
    chk("single out_data", 32'(od_rr), 32'hBEEF);
    chk("single out_sel", 32'(os_rr), 32'h4);
    chk("single gnt after", 32'(gnt_rr), 32'h0);
    tick();
    at_neg();
    chk("drain out_valid", 32'(ov_rr), 32'h0);
    chk("drain busy", 32'(busy_rr), 32'h0);

    // Backpressure: five stalled cycles with churning req and data
    tick();
    req = 16'h0100;
    in_data = '0;
    in_data[143:128] = 16'h1234;
    out_ready = 1'b0;
    at_neg();
    chk("bp grant", 32'(gnt_rr), 32'h0100);
    for (int i = 0; i < 5; i++) begin
      tick();
      req = 16'hFFFF >> i;
      for (int k = 0; k < 8; k++) in_data[k*32 +: 32] = $urandom;
      at_neg();
      chk("bp out_data", 32'(od_rr), 32'h1234);
      chk("bp out_sel", 32'(os_rr), 32'h8);
      chk("bp out_valid", 32'(ov_rr), 32'h1);
      chk("bp gnt", 32'(gnt_rr), 32'h0);
    end
    tick();
    req = 16'h0000;
    out_ready = 1'b1;
    tick();
    at_neg();
    chk("bp drained", 32'(ov_rr), 32'h0);

    // Round-robin wrap vs fixed priority, starting from a fresh pointer
    rst_n = 1'b0;
    req = 16'h8001;
    at_neg();
    chk("gnt in reset rr", 32'(gnt_rr), 32'h0);
    chk("gnt in reset fp", 32'(gnt_fp), 32'h0);
    tick();
    rst_n = 1'b1;
    at_neg();
    chk("wrap first gnt rr", 32'(gnt_rr), 32'h0001);
    chk("wrap first gnt fp", 32'(gnt_fp), 32'h0001);
    for (int i = 0; i < 4; i++) begin
      tick();
      at_neg();
      chk("wrap out_sel rr", 32'(os_rr), (i % 2 == 0) ? 32'h0 : 32'hF);
      chk("wrap gnt rr", 32'(gnt_rr), (i % 2 == 0) ? 32'h8000 : 32'h0001);
      chk("wrap no bubble", 32'(ov_rr), 32'h1);
      chk("fixed out_sel", 32'(os_fp), 32'h0);
      chk("fixed gnt", 32'(gnt_fp), 32'h0001);
    end

    // Reset in the middle of a stalled transfer
    out_ready = 1'b0;
    tick();
    at_neg();
    chk("pre-reset hold", 32'(ov_rr), 32'h1);
    rst_n = 1'b0;
    req = 16'hFFFF;
    in_data[15:0] = 16'hCAFE;
    at_neg();
    chk("mid-hold reset gnt", 32'(gnt_rr), 32'h0);
    tick();
    rst_n = 1'b1;
    at_neg();
    chk("post-reset out_valid", 32'(ov_rr), 32'h0);
    chk("post-reset out_data", 32'(od_rr), 32'h0);
    chk("post-reset out_sel", 32'(os_rr), 32'h0);
    chk("post-reset gnt", 32'(gnt_rr), 32'h0001);
    tick();
    at_neg();
    chk("post-reset first sel", 32'(os_rr), 32'h0);
    chk("post-reset first data", 32'(od_rr), 32'hCAFE);
    out_ready = 1'b1;
    req = 16'h0000;
    tick();
    tick();

    // Mixed traffic checked by the model alone
    for (int c = 0; c < 400; c++) begin
      tick();
      req       = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom & $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 60) != 0);
      for (int k = 0; k < 8; k++) in_data[k*32 +: 32] = $urandom;
    end
    tick();
    rst_n = 1'b1;
    req = 16'h0000;
    tick();
    at_neg();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
